vga_scan_generator: RTL and testbench

- Free-running 640x480 @ 60 Hz VGA raster scan generator on the 25 MHz pixel clock.
- Produces the X/Y pixel coordinates consumed by the start/game-over printer and the snake/food renderers, plus hsync/vsync to the DAC connector.
- Also produces the video_on blanking qualifier and the line_start/frame_start strobes used by the game logic for per-frame updates.

---
 rtl/vga_scan_generator.sv | 125 ++++++++++++
 tb/tb_vga_scan_generator.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_generator.sv
// ---------------------------------------------------------------------------
// vga_scan_generator
//
// Free-running VGA raster scan generator. The default timing is 640x480 @ 60 Hz
// on a 25 MHz pixel clock. It walks the full horizontal and vertical totals,
// including the blanking intervals. Every output is registered from the current
// counter state, so outputs trail the counters by one enabled cycle.
//
// Ports:
//   clock_25     in   pixel clock
//   reset        in   asynchronous, active-high reset
//   scan_enable  in   1 = advance the raster, 0 = freeze counters and outputs
//   X, Y         out  emitted pixel coordinate (0..H_TOTAL-1, 0..V_TOTAL-1)
//   hsync        out  horizontal sync, active low
//   vsync        out  vertical sync, active low
//   video_on     out  emitted coordinate lies in the visible area
//   line_start   out  high when the emitted X is 0
//   frame_start  out  high when the emitted X and Y are both 0
// ---------------------------------------------------------------------------
module vga_scan_generator #(
    parameter int PIXEL_DISPLAY_BIT = 9,
    parameter int H_VISIBLE         = 640,
    parameter int H_FRONT           = 16,
    parameter int H_SYNC            = 96,
    parameter int H_BACK            = 48,
    parameter int V_VISIBLE         = 480,
    parameter int V_FRONT           = 10,
    parameter int V_SYNC            = 2,
    parameter int V_BACK            = 33
) (
    input  logic                       clock_25,
    input  logic                       reset,
    input  logic                       scan_enable,
    output logic [PIXEL_DISPLAY_BIT:0] X,
    output logic [PIXEL_DISPLAY_BIT:0] Y,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       video_on,
    output logic                       line_start,
    output logic                       frame_start
);

    localparam int W       = PIXEL_DISPLAY_BIT + 1;
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Thresholds in counter width, so that every compare below has matching widths.
    localparam logic [W-1:0] H_VIS_END  = W'(H_VISIBLE);
    localparam logic [W-1:0] H_SYNC_BEG = W'(H_VISIBLE + H_FRONT);
    localparam logic [W-1:0] H_SYNC_END = W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [W-1:0] H_LAST     = W'(H_TOTAL - 1);
    localparam logic [W-1:0] V_VIS_END  = W'(V_VISIBLE);
    localparam logic [W-1:0] V_SYNC_BEG = W'(V_VISIBLE + V_FRONT);
    localparam logic [W-1:0] V_SYNC_END = W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [W-1:0] V_LAST     = W'(V_TOTAL - 1);

    logic [W-1:0] r_h_cnt;
    logic [W-1:0] r_v_cnt;
    logic [W-1:0] r_x;
    logic [W-1:0] r_y;
    logic         r_hsync;
    logic         r_vsync;
    logic         r_video_on;
    logic         r_line_start;
    logic         r_frame_start;

    // Decode of the current counter state. It is registered below, never driven to a port directly.
    logic w_h_last;
    logic w_v_last;
    logic w_video_on;
    logic w_hsync;
    logic w_vsync;
    logic w_line_start;
    logic w_frame_start;

    assign w_h_last      = (r_h_cnt == H_LAST);
    assign w_v_last      = (r_v_cnt == V_LAST);
    assign w_video_on    = (r_h_cnt < H_VIS_END) && (r_v_cnt < V_VIS_END);
    assign w_hsync       = !((r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END));
    assign w_vsync       = !((r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END));
    assign w_line_start  = (r_h_cnt == '0);
    assign w_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);

    // NOTE: sequential state uses non-blocking assignments. Every register then
    // samples the pre-edge counter values, and that gives the one-cycle latency.
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video_on    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (scan_enable) begin
            r_x           <= r_h_cnt;
            r_y           <= r_v_cnt;
            r_hsync       <= w_hsync;
            r_vsync       <= w_vsync;
            r_video_on    <= w_video_on;
            r_line_start  <= w_line_start;
            r_frame_start <= w_frame_start;

            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
        // When scan_enable is low, nothing is assigned, so the counters, the
        // outputs and any strobe that is high all hold their values.
    end

    assign X           = r_x;
    assign Y           = r_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_scan_generator.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_generator
//
// Two instances share the clock, reset and scan_enable:
//   dut_a : default 640x480 timing (line-level behaviour, freeze)
//   dut_b : reduced timing 25x15 (whole-frame behaviour, sync window, reset)
// Each posedge, a reference model pushes the expected output of both instances
// onto a queue. A monitor on the falling edge pops from the queue and compares.
// Directed checks against hand-computed constants cover the called-out points.
// ---------------------------------------------------------------------------
module tb_vga_scan_generator;

    // dut_a timing (defaults); totals 800 x 525
    localparam int AHV = 640, AHF = 16, AHS = 96, AHB = 48;
    localparam int AVV = 480, AVF = 10, AVS = 2,  AVB = 33;
    localparam int ATH = 800, ATV = 525;
    // dut_b timing; totals 25 x 15, frame = 375 cycles
    localparam int BHV = 16, BHF = 2, BHS = 4, BHB = 3;
    localparam int BVV = 8,  BVF = 2, BVS = 2, BVB = 3;
    localparam int BTH = 25, BTV = 15;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       ls;
        logic       fs;
    } out_t;

    typedef struct {
        out_t a;
        out_t b;
    } pair_t;

    localparam out_t RST_OUT   = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, von: 1'b0, ls: 1'b0, fs: 1'b0};
    localparam out_t FIRST_OUT = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, von: 1'b1, ls: 1'b1, fs: 1'b1};

    logic clk;
    logic reset;
    logic scan_enable;

    logic [9:0] ax, ay;
    logic       ahs, avs, avon, als, afs;
    logic [4:0] bx, by;
    logic       bhs, bvs, bvon, bls, bfs;

    out_t act_a, act_b;
    assign act_a = {ax, ay, ahs, avs, avon, als, afs};
    assign act_b = {5'd0, bx, 5'd0, by, bhs, bvs, bvon, bls, bfs};

    vga_scan_generator dut_a (
        .clock_25    (clk),
        .reset       (reset),
        .scan_enable (scan_enable),
        .X           (ax),
        .Y           (ay),
        .hsync       (ahs),
        .vsync       (avs),
        .video_on    (avon),
        .line_start  (als),
        .frame_start (afs)
    );

    vga_scan_generator #(
        .PIXEL_DISPLAY_BIT (4),
        .H_VISIBLE (BHV), .H_FRONT (BHF), .H_SYNC (BHS), .H_BACK (BHB),
        .V_VISIBLE (BVV), .V_FRONT (BVF), .V_SYNC (BVS), .V_BACK (BVB)
    ) dut_b (
        .clock_25    (clk),
        .reset       (reset),
        .scan_enable (scan_enable),
        .X           (bx),
        .Y           (by),
        .hsync       (bhs),
        .vsync       (bvs),
        .video_on    (bvon),
        .line_start  (bls),
        .frame_start (bfs)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: the emitted values for a counter position.
    function automatic out_t dec(input int h, input int v, input int hv, input int hf,
                                 input int hsw, input int vv, input int vf, input int vsw);
        out_t o;
        o.x   = 10'(h);
        o.y   = 10'(v);
        o.hs  = !((h >= hv + hf) && (h < hv + hf + hsw));
        o.vs  = !((v >= vv + vf) && (v < vv + vf + vsw));
        o.von = (h < hv) && (v < vv);
        o.ls  = (h == 0);
        o.fs  = (h == 0) && (v == 0);
        return o;
    endfunction

    // ---------------- scoreboard: model pushes, monitor pops ----------------
    pair_t sb_q[$];
    int    ma_h, ma_v, mb_h, mb_v;
    out_t  ea_hold, eb_hold;

    always @(posedge clk) begin
        if (reset) begin
            ma_h <= 0; ma_v <= 0; mb_h <= 0; mb_v <= 0;
            ea_hold <= RST_OUT;
            eb_hold <= RST_OUT;
            sb_q.push_back('{a: RST_OUT, b: RST_OUT});
        end else if (scan_enable) begin
            ea_hold <= dec(ma_h, ma_v, AHV, AHF, AHS, AVV, AVF, AVS);
            eb_hold <= dec(mb_h, mb_v, BHV, BHF, BHS, BVV, BVF, BVS);
            sb_q.push_back('{a: dec(ma_h, ma_v, AHV, AHF, AHS, AVV, AVF, AVS),
                             b: dec(mb_h, mb_v, BHV, BHF, BHS, BVV, BVF, BVS)});
            if (ma_h == ATH - 1) begin
                ma_h <= 0;
                ma_v <= (ma_v == ATV - 1) ? 0 : ma_v + 1;
            end else begin
                ma_h <= ma_h + 1;
            end
            if (mb_h == BTH - 1) begin
                mb_h <= 0;
                mb_v <= (mb_v == BTV - 1) ? 0 : mb_v + 1;
            end else begin
                mb_h <= mb_h + 1;
            end
        end else begin
            sb_q.push_back('{a: ea_hold, b: eb_hold});
        end
    end

    always @(negedge clk) begin
        pair_t p;
        if (sb_q.size() > 0) begin
            p = sb_q.pop_front();
            check("sb_a", 32'(act_a), 32'(p.a));
            check("sb_b", 32'(act_b), 32'(p.b));
        end
    end

    // ---------------- directed stimulus and checks ----------------
    int  a_von_cnt, a_hs_cnt, a_hs_first, a_hs_last;
    int  b_vs_cnt, b_vs_ymin, b_vs_ymax, b_fs_cnt, b_fs_last;
    int  win_cnt, win_dup, win_von_bad;
    bit  seen [0:14][0:24];
    bit  found;

    initial begin
        reset       = 1'b1;
        scan_enable = 1'b0;
        a_von_cnt = 0; a_hs_cnt = 0; a_hs_first = -1; a_hs_last = -1;
        b_vs_cnt = 0; b_vs_ymin = 99; b_vs_ymax = -1; b_fs_cnt = 0; b_fs_last = -1;
        win_cnt = 0; win_dup = 0; win_von_bad = 0;
        for (int yy = 0; yy < 15; yy++)
            for (int xx = 0; xx < 25; xx++)
                seen[yy][xx] = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_a", 32'(act_a), 32'(RST_OUT));
        check("reset_b", 32'(act_b), 32'(RST_OUT));

        #1;
        reset       = 1'b0;
        scan_enable = 1'b1;

        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("first_edge_a", 32'(act_a), 32'(FIRST_OUT));
                check("first_edge_b", 32'(act_b), 32'(FIRST_OUT));
            end
            // dut_a: first line statistics, then the wrap to line 1
            if (i < 800) begin
                if (avon) a_von_cnt++;
                if (!ahs) begin
                    a_hs_cnt++;
                    if (a_hs_first < 0) a_hs_first = int'(ax);
                    a_hs_last = int'(ax);
                end
            end
            if (i == 799) check("a_line_end_xy", {ax, ay}, {10'd799, 10'd0});
            if (i == 800) check("a_line_wrap", {ax, ay, als, afs}, {10'd0, 10'd1, 1'b1, 1'b0});
            // dut_b: first frame statistics
            if (i < 375) begin
                if (!bvs) begin
                    b_vs_cnt++;
                    if (int'(by) < b_vs_ymin) b_vs_ymin = int'(by);
                    if (int'(by) > b_vs_ymax) b_vs_ymax = int'(by);
                end
                if (by >= 5'd3 && by <= 5'd5 && bx >= 5'd5 && bx <= 5'd9) begin
                    win_cnt++;
                    if (seen[by][bx]) win_dup++;
                    seen[by][bx] = 1'b1;
                    if (!bvon) win_von_bad++;
                end
            end
            if (i == 374) check("b_frame_last", {bx, by, bfs}, {5'd24, 5'd14, 1'b0});
            if (i == 375) check("b_frame_wrap", {bx, by, bls, bfs}, {5'd0, 5'd0, 1'b1, 1'b1});
            if (bfs) begin
                if (b_fs_last >= 0) check("b_frame_gap", i - b_fs_last, 375);
                b_fs_last = i;
                b_fs_cnt++;
            end
        end

        check("a_video_on_cnt", a_von_cnt, 640);
        check("a_hsync_low_cnt", a_hs_cnt, 96);
        check("a_hsync_first_x", a_hs_first, 656);
        check("a_hsync_last_x", a_hs_last, 751);
        check("b_vsync_low_cnt", b_vs_cnt, 50);
        check("b_vsync_ymin", b_vs_ymin, 10);
        check("b_vsync_ymax", b_vs_ymax, 11);
        check("b_frame_pulses", b_fs_cnt, 3);
        check("b_window_cnt", win_cnt, 15);
        check("b_window_dup", win_dup, 0);
        check("b_window_von", win_von_bad, 0);

        // Freeze dut_a at X=300 for 50 cycles.
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(negedge clk);
            if (ax == 10'd300) found = 1'b1;
        end
        check("freeze_reach", 32'(found), 32'd1);
        #1 scan_enable = 1'b0;
        repeat (50) @(negedge clk);
        check("freeze_hold_a", {ax, ay}, {10'd300, 10'd1});
        #1 scan_enable = 1'b1;
        @(negedge clk);
        check("freeze_resume_a", {ax, ay}, {10'd301, 10'd1});

        // Reset dut_b while both syncs are low.
        found = 1'b0;
        for (int k = 0; k < 1000 && !found; k++) begin
            @(negedge clk);
            if (!bhs && !bvs) found = 1'b1;
        end
        check("sync_reach_b", 32'(found), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async_reset_a", 32'(act_a), 32'(RST_OUT));
        check("async_reset_b", 32'(act_b), 32'(RST_OUT));
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("restart_a", 32'(act_a), 32'(FIRST_OUT));
        check("restart_b", 32'(act_b), 32'(FIRST_OUT));
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
